// File: rtl/dc_block_mc.sv
// Multi-channel DC blocker: y[k] = (x[k] - x[k-1]) + (1 - 2^-shift) * y[k-1].
// One shared datapath processes one channel per clock. Each y state keeps G guard bits.
module dc_block_mc #(
  parameter int W     = 16,
  parameter int N_CH  = 4,
  parameter int G     = 8,
  parameter int SHIFT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH*W-1:0] sample_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      shift,
  input  logic            bypass,
  output logic [N_CH*W-1:0] sample_out,
  output logic            out_valid,
  output logic            overrun
);

  localparam int YW = W + G;
  localparam int AW = W + G + 2;
  localparam int SW = $clog2(YW);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic signed [AW-1:0] ACC_MAX = {{(AW-YW+1){1'b0}}, {(YW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(AW-YW+1){1'b1}}, {(YW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: a frame transfers on a clk edge where in_valid & in_ready are both high.
  // in_ready is high only in IDLE; there is no backpressure on the output side.
  state_t                 state;
  logic [CW-1:0]          ch;
  logic [N_CH*W-1:0]      x_q;
  logic [SW-1:0]          shift_q;
  logic                   bypass_q;
  logic signed [W-1:0]    x1 [N_CH];
  logic signed [YW-1:0]   y  [N_CH];

  logic [SW-1:0]          shift_clamped;
  logic signed [W-1:0]    x_cur;
  logic signed [W-1:0]    x1_cur;
  logic signed [YW-1:0]   y_cur;
  logic signed [W:0]      d;
  logic signed [AW-1:0]   acc;
  logic signed [YW-1:0]   y_next;

  assign in_ready = ~rst_n | (state == IDLE);

  always_comb begin
    shift_clamped = SW'(shift);
    if (shift == 4'd0)
      shift_clamped = SW'(1);
    else if (int'(shift) > YW - 1)
      shift_clamped = SW'(YW - 1);
  end

  // The accumulator is two bits wider than y so the sum can never wrap before saturation.
  always_comb begin
    x_cur  = x_q[ch*W +: W];
    x1_cur = x1[ch];
    y_cur  = y[ch];
    d      = (W+1)'(x_cur) - (W+1)'(x1_cur);
    acc    = (AW'(d) <<< G) + AW'(y_cur) - AW'(y_cur >>> shift_q);
    if (acc > ACC_MAX)
      y_next = ACC_MAX[YW-1:0];
    else if (acc < ACC_MIN)
      y_next = ACC_MIN[YW-1:0];
    else
      y_next = acc[YW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= '0;
      x_q        <= '0;
      shift_q    <= SW'(SHIFT);
      bypass_q   <= 1'b0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        x1[c] <= '0;
        y[c]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= sample_in;
            shift_q  <= shift_clamped;
            bypass_q <= bypass;
            ch       <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          x1[ch] <= x_cur;
          // Bypass zeroes y so leaving bypass restarts from the held x1 without a transient.
          if (bypass_q) begin
            y[ch]                  <= '0;
            sample_out[ch*W +: W]  <= x_cur;
          end else begin
            y[ch]                  <= y_next;
            sample_out[ch*W +: W]  <= y_next[G +: W];
          end
          if (ch == CW'(N_CH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_block_mc.sv
// Scoreboard bench for dc_block_mc: directed frames push per-channel [lo,hi] bounds,
// a negedge monitor pops and compares on every out_valid.
module tb_dc_block_mc;
  localparam int W    = 16;
  localparam int N_CH = 4;
  localparam int FW   = W * N_CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] sample_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    shift = 4'd8;
  logic          bypass = 1'b0;
  logic [FW-1:0] sample_out;
  logic          out_valid;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ov_count = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_hi_q[$];
  string         name_q[$];

  dc_block_mc dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .in_valid(in_valid),
    .in_ready(in_ready), .shift(shift), .bypass(bypass), .sample_out(sample_out),
    .out_valid(out_valid), .overrun(overrun)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] frame4(int a, int b, int c, int d);
    logic [FW-1:0] f;
    f = '0;
    f[0*W +: W] = W'(a);
    f[1*W +: W] = W'(b);
    f[2*W +: W] = W'(c);
    f[3*W +: W] = W'(d);
    return f;
  endfunction

  task automatic check(string nm, logic [63:0] got, logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic push(logic [FW-1:0] lo, logic [FW-1:0] hi, string nm);
    exp_q.push_back(lo);
    exp_hi_q.push_back(hi);
    name_q.push_back(nm);
  endtask

  // Waits for in_ready, presents one frame for one accept edge, returns #1 after that edge.
  task automatic send(logic [FW-1:0] f, logic byp, logic [FW-1:0] lo, logic [FW-1:0] hi,
                      string nm, bit chk);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept_timeout in_ready=%b required=1", nm, in_ready);
      return;
    end
    sample_in = f;
    shift     = 4'd8;
    bypass    = byp;
    in_valid  = 1'b1;
    if (chk) push(lo, hi, nm);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_exact(logic [FW-1:0] f, logic byp, logic [FW-1:0] e, string nm);
    send(f, byp, e, e, nm, 1'b1);
  endtask

  task automatic drain(string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(nm, 64'(exp_q.size()), 64'(0));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [FW-1:0] lo;
    logic [FW-1:0] hi;
    string nm;
    logic ok;
    int v;
    int l;
    int h;
    if (rst_n && out_valid) begin
      ov_count++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid got=%h required=no output", sample_out);
      end else begin
        lo = exp_q.pop_front();
        hi = exp_hi_q.pop_front();
        nm = name_q.pop_front();
        ok = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
          v = int'($signed(sample_out[c*W +: W]));
          l = int'($signed(lo[c*W +: W]));
          h = int'($signed(hi[c*W +: W]));
          if (v < l || v > h) ok = 1'b0;
        end
        if (!ok) begin
          n_err++;
          $display("FAIL %s got=%h required lo=%h hi=%h", nm, sample_out, lo, hi);
        end
      end
    end
  end

  initial begin
    int lat;
    int t;
    int tk[3];
    logic [FW-1:0] lo_f;
    logic [FW-1:0] hi_f;
    logic [FW-1:0] t5_exp[3];
    int cnt0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sample_out", 64'(sample_out), 64'(0));
    check("reset_overrun", 64'(overrun), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // first impulse-like frame and its latency
    send_exact(frame4(1000, 0, 0, 0), 1'b0, frame4(1000, 0, 0, 0), "first_frame");
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("accept_to_out_valid_edges", 64'(lat), 64'(N_CH));

    // steady DC on ch0: decay to ~1000/e after 256 frames, exactly 0 after 4096
    for (int i = 1; i <= 4096; i++) begin
      if (i == 256) begin
        lo_f = frame4(366, 0, 0, 0);
        hi_f = frame4(370, 0, 0, 0);
      end else if (i == 4096) begin
        lo_f = frame4(0, 0, 0, 0);
        hi_f = frame4(0, 0, 0, 0);
      end else begin
        lo_f = frame4(0, 0, 0, 0);
        hi_f = frame4(1000, 0, 0, 0);
      end
      send(frame4(1000, 0, 0, 0), 1'b0, lo_f, hi_f, $sformatf("dc_hold_%0d", i), 1'b1);
    end

    // full-scale step on ch1 saturates, then decays without sign flip
    send_exact(frame4(1000, -32768, 0, 0), 1'b0, frame4(0, -32768, 0, 0), "step_neg");
    send_exact(frame4(1000, 32767, 0, 0), 1'b0, frame4(0, 32767, 0, 0), "step_sat");
    send_exact(frame4(1000, 32767, 0, 0), 1'b0, frame4(0, 32640, 0, 0), "step_decay");

    // bypass passes through; leaving bypass with the same frame gives zero
    send_exact(frame4(5, -7, 123, -32768), 1'b1, frame4(5, -7, 123, -32768), "bypass_on");
    send_exact(frame4(5, -7, 123, -32768), 1'b0, frame4(0, 0, 0, 0), "bypass_off");
    drain("drain_before_stream");
    check("overrun_before_stream", 64'(overrun), 64'(0));

    // in_valid held high: accepts every N_CH+2 cycles, drops set overrun
    t5_exp[0] = frame4(195, -293, -123, 32767);
    t5_exp[1] = frame4(194, -292, -123, 32640);
    t5_exp[2] = frame4(193, -291, -123, 32512);
    @(negedge clk);
    sample_in = frame4(200, -300, 0, 0);
    bypass    = 1'b0;
    shift     = 4'd8;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("stream_ready_%0d", k), 64'(in_ready), 64'(1));
      push(t5_exp[k], t5_exp[k], $sformatf("stream_%0d", k));
      tk[k] = cyc;
      @(negedge clk);
      if (k == 0) begin
        check("overrun_not_yet", 64'(overrun), 64'(0));
        @(negedge clk);
        check("overrun_after_busy", 64'(overrun), 64'(1));
      end
    end
    in_valid = 1'b0;
    check("stream_spacing_01", 64'(tk[1] - tk[0]), 64'(N_CH + 2));
    check("stream_spacing_12", 64'(tk[2] - tk[1]), 64'(N_CH + 2));
    drain("drain_after_stream");

    // reset while ch=2 is in flight: frame abandoned, state cleared
    @(negedge clk);
    sample_in = frame4(7, 7, 7, 7);
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt0 = ov_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("in_ready_during_reset", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset_sample_out", 64'(sample_out), 64'(0));
    check("midrun_reset_overrun", 64'(overrun), 64'(0));
    repeat (8) @(negedge clk);
    check("abandoned_frame_no_out_valid", 64'(ov_count - cnt0), 64'(0));
    send_exact(frame4(100, 0, 0, 0), 1'b0, frame4(100, 0, 0, 0), "after_reset");
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
